// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the AXI4-lite register block: response codes,
// channel state encodings and the register map size.
package axi_lite_pkg;

  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;
  localparam logic [31:0] REG_VERSION = 32'hA11E_0001;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic [1:0] {
    W_IDLE      = 2'b00,
    W_WAIT_DATA = 2'b01,
    W_WAIT_ADDR = 2'b10,
    W_RESP      = 2'b11
  } wstate_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_e;

  function automatic resp_e resp_of(input logic i_ok);
    resp_of = i_ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational address decode shared by the read and write channels:
// register index, in-map flag and read-only (version register) flag.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int ADDR_SIZE = 32
) (
  input  logic [ADDR_SIZE-1:0] i_addr,
  output logic [IDX_W-1:0]     o_index,
  output logic                 o_valid,
  output logic                 o_read_only
);

  // Word-aligned addresses inside the 64-byte window are the only legal ones
  always_comb begin
    o_index     = i_addr[5:2];
    o_valid     = (i_addr[1:0] == 2'b00) && (i_addr[ADDR_SIZE-1:6] == '0);
    o_read_only = o_valid && (o_index == IDX_W'(NUM_REGS - 1));
  end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-lite responder with 15 read/write registers plus a read-only version
// register; independent single-beat write and read channels.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int ID_SIZE   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [ADDR_SIZE-1:0] awaddr,
  input  logic [ID_SIZE-1:0]   awid,
  input  logic                 wvalid,
  output logic                 wready,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 wlast,
  output logic                 bvalid,
  input  logic                 bready,
  output logic [1:0]           bresp,
  output logic [ID_SIZE-1:0]   bid,
  input  logic                 arvalid,
  output logic                 arready,
  input  logic [ADDR_SIZE-1:0] araddr,
  input  logic [ID_SIZE-1:0]   arid,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 rlast,
  output logic [ID_SIZE-1:0]   rid,
  output logic [1:0]           rresp
);

  wstate_e              r_wstate;
  rstate_e              r_rstate;
  logic                 r_awready, r_wready, r_bvalid, r_arready, r_rvalid, r_rlast;
  resp_e                r_bresp, r_rresp;
  logic [ID_SIZE-1:0]   r_bid, r_rid, r_awid;
  logic [ADDR_SIZE-1:0] r_awaddr;
  logic [DATA_SIZE-1:0] r_wdata, r_rdata;
  logic [DATA_SIZE-1:0] r_regs [NUM_REGS-1];

  logic                 w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wr_en;
  logic [ADDR_SIZE-1:0] w_waddr;
  logic [DATA_SIZE-1:0] w_wdata_sel, w_rdata_sel;
  logic [ID_SIZE-1:0]   w_wid;
  logic [IDX_W-1:0]     w_widx, w_ridx;
  logic                 w_wdec_valid, w_wdec_ro, w_rdec_valid, w_rdec_ro;
  resp_e                w_wresp;
  logic                 w_unused;

  assign w_unused = wlast;

  axi_lite_addr_decode #(.ADDR_SIZE(ADDR_SIZE)) u_wdec (
    .i_addr(w_waddr), .o_index(w_widx), .o_valid(w_wdec_valid), .o_read_only(w_wdec_ro)
  );

  axi_lite_addr_decode #(.ADDR_SIZE(ADDR_SIZE)) u_rdec (
    .i_addr(araddr), .o_index(w_ridx), .o_valid(w_rdec_valid), .o_read_only(w_rdec_ro)
  );

  // Handshakes, commit detection and the write operand mux (held vs. live beat)
  always_comb begin
    w_aw_hs = awvalid && r_awready;
    w_w_hs  = wvalid && r_wready;
    w_ar_hs = arvalid && r_arready;
    case (r_wstate)
      W_IDLE:      w_commit = w_aw_hs && w_w_hs;
      W_WAIT_DATA: w_commit = w_w_hs;
      W_WAIT_ADDR: w_commit = w_aw_hs;
      default:     w_commit = 1'b0;
    endcase
    w_waddr     = (r_wstate == W_WAIT_DATA) ? r_awaddr : awaddr;
    w_wid       = (r_wstate == W_WAIT_DATA) ? r_awid : awid;
    w_wdata_sel = (r_wstate == W_WAIT_ADDR) ? r_wdata : wdata;
    w_wresp     = resp_of(w_wdec_valid && !w_wdec_ro);
    w_wr_en     = w_commit && w_wdec_valid && !w_wdec_ro;
  end

  // Read data mux: out-of-map reads return zero
  always_comb begin
    if (!w_rdec_valid) begin
      w_rdata_sel = '0;
    end else if (w_rdec_ro) begin
      w_rdata_sel = DATA_SIZE'(REG_VERSION);
    end else begin
      w_rdata_sel = r_regs[w_ridx];
    end
  end

  // Register file, written on the edge that enters W_RESP
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[w_widx] <= w_wdata_sel;
    end
  end

  // Write channel FSM; readies come up on the first edge after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      r_awaddr  <= '0;
      r_awid    <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE, W_WAIT_DATA, W_WAIT_ADDR: begin
          if (w_commit) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wresp;
            r_bid     <= w_wid;
          end else if (r_wstate == W_IDLE && w_aw_hs) begin
            r_wstate  <= W_WAIT_DATA;
            r_awaddr  <= awaddr;
            r_awid    <= awid;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
          end else if (r_wstate == W_IDLE && w_w_hs) begin
            r_wstate  <= W_WAIT_ADDR;
            r_wdata   <= wdata;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
          end else if (r_wstate == W_IDLE) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (bready) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: begin
          r_wstate  <= W_IDLE;
          r_awready <= 1'b0;
          r_wready  <= 1'b0;
          r_bvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM; data is sampled on the address handshake edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rlast   <= 1'b1;
            r_rdata   <= w_rdata_sel;
            r_rresp   <= resp_of(w_rdec_valid);
            r_rid     <= arid;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: begin
          r_rstate  <= R_IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
          r_rlast   <= 1'b0;
        end
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign bid     = r_bid;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rlast   = r_rlast;
  assign rid     = r_rid;
  assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Directed bench for axi_lite_slave_regs: hand-computed vectors for writes,
// reads, decode errors, backpressure, read/write collision and mid-write reset.
module tb_axi_lite_slave_regs;

  logic        clk, reset_n;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, awid, wdata, bid, araddr, arid, rdata, rid;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready, rlast;

  int n_checks = 0;
  int n_pass   = 0;

  axi_lite_slave_regs dut (
    .clk(clk), .reset_n(reset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .rid(rid), .rresp(rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [31:0] id,
                          output logic [1:0] resp_o, output logic [31:0] bid_o, output int lat_o);
    logic aw_pend, w_pend, a_hs, d_hs;
    int   n;
    awvalid = 1'b1; awaddr = addr; awid = id;
    wvalid  = 1'b1; wdata = data;
    aw_pend = 1'b1; w_pend = 1'b1; n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      a_hs = aw_pend && awready;
      d_hs = w_pend && wready;
      tick();
      n++;
      if (a_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
      if (d_hs) begin wvalid = 1'b0; w_pend = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_handshake_done", {aw_pend, w_pend}, 2'b00);
    lat_o = 0;
    while (!bvalid && lat_o < 20) begin
      tick();
      lat_o++;
    end
    chk("wr_bvalid_seen", bvalid, 1'b1);
    resp_o = bresp;
    bid_o  = bid;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] id,
                         output logic [31:0] data_o, output logic [1:0] resp_o,
                         output logic [31:0] rid_o, output logic rlast_o);
    int n;
    arvalid = 1'b1; araddr = addr; arid = id;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      tick();
      n++;
    end
    chk("rd_rvalid_seen", rvalid, 1'b1);
    data_o  = rdata;
    resp_o  = rresp;
    rid_o   = rid;
    rlast_o = rlast;
    rready  = 1'b1;
    tick();
    rready  = 1'b0;
  endtask

  logic [1:0]  t_resp;
  logic [31:0] t_id, t_data;
  logic        t_last;
  int          t_lat;

  initial begin
    reset_n = 1'b0;
    awvalid = 1'b0; awaddr = '0; awid = '0;
    wvalid = 1'b0; wdata = '0; wlast = 1'b1; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; arid = '0; rready = 1'b0;
    repeat (3) tick();

    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid, rlast}, 3'b000);
    chk("rst_resps", {bresp, rresp}, 4'b0000);
    chk("rst_ids", {bid, rid}, 64'h0);
    chk("rst_rdata", rdata, 32'h0);

    reset_n = 1'b1;
    tick();
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);

    // Same-cycle aw/w, one-cycle response latency
    do_write(32'h04, 32'hDEADBEEF, 32'd3, t_resp, t_id, t_lat);
    chk("w04_lat", t_lat, 0);
    chk("w04_bresp", t_resp, 2'b00);
    chk("w04_bid", t_id, 32'd3);
    do_read(32'h04, 32'd11, t_data, t_resp, t_id, t_last);
    chk("r04_data", t_data, 32'hDEADBEEF);
    chk("r04_rlast", t_last, 1'b1);
    chk("r04_rresp", t_resp, 2'b00);
    chk("r04_rid", t_id, 32'd11);

    // Data three cycles ahead of address
    wvalid = 1'b1; wdata = 32'h12345678;
    tick();
    wvalid = 1'b0;
    chk("w08_hold_ready", {awready, wready}, 2'b10);
    tick(); tick();
    chk("w08_no_early_resp", bvalid, 1'b0);
    awvalid = 1'b1; awaddr = 32'h08; awid = 32'd5;
    tick();
    awvalid = 1'b0;
    chk("w08_bvalid", bvalid, 1'b1);
    chk("w08_bresp", bresp, 2'b00);
    chk("w08_bid", bid, 32'd5);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("w08_bvalid_drop", bvalid, 1'b0);
    do_read(32'h08, 32'd1, t_data, t_resp, t_id, t_last);
    chk("r08_data", t_data, 32'h12345678);

    // Decode errors and the read-only version register
    do_write(32'h3C, 32'hFFFFFFFF, 32'd1, t_resp, t_id, t_lat);
    chk("w3C_slverr", t_resp, 2'b10);
    do_write(32'h40, 32'h11111111, 32'd1, t_resp, t_id, t_lat);
    chk("w40_slverr", t_resp, 2'b10);
    do_write(32'h06, 32'h22222222, 32'd1, t_resp, t_id, t_lat);
    chk("w06_slverr", t_resp, 2'b10);
    do_read(32'h3C, 32'd2, t_data, t_resp, t_id, t_last);
    chk("r3C_version", t_data, 32'hA11E0001);
    chk("r3C_okay", t_resp, 2'b00);
    do_read(32'h40, 32'd2, t_data, t_resp, t_id, t_last);
    chk("r40_slverr", t_resp, 2'b10);
    chk("r40_zero", t_data, 32'h0);
    do_read(32'h06, 32'd2, t_data, t_resp, t_id, t_last);
    chk("r06_slverr", t_resp, 2'b10);
    chk("r06_zero", t_data, 32'h0);
    do_read(32'h00, 32'd2, t_data, t_resp, t_id, t_last);
    chk("r00_untouched", t_data, 32'h0);
    do_read(32'h04, 32'd2, t_data, t_resp, t_id, t_last);
    chk("r04_untouched", t_data, 32'hDEADBEEF);

    // Write response backpressure
    awvalid = 1'b1; awaddr = 32'h0C; awid = 32'd7;
    wvalid = 1'b1; wdata = 32'h0BADF00D;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", bvalid, 1'b1);
      chk("bp_bid", bid, 32'd7);
      chk("bp_bresp", bresp, 2'b00);
      chk("bp_readies", {awready, wready}, 2'b00);
      tick();
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bp_bvalid_drop", bvalid, 1'b0);

    // Read data backpressure
    arvalid = 1'b1; araddr = 32'h0C; arid = 32'd8;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rp_rvalid", rvalid, 1'b1);
      chk("rp_rdata", rdata, 32'h0BADF00D);
      chk("rp_arready", arready, 1'b0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rp_rvalid_drop", rvalid, 1'b0);

    // Read captured on the same edge as a write commit returns the old value
    do_write(32'h10, 32'h55, 32'd1, t_resp, t_id, t_lat);
    wvalid = 1'b1; wdata = 32'hAA;
    tick();
    wvalid = 1'b0;
    awvalid = 1'b1; awaddr = 32'h10; awid = 32'd9;
    arvalid = 1'b1; araddr = 32'h10; arid = 32'd4;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("col_bvalid", bvalid, 1'b1);
    chk("col_rvalid", rvalid, 1'b1);
    chk("col_rdata_old", rdata, 32'h55);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    do_read(32'h10, 32'd4, t_data, t_resp, t_id, t_last);
    chk("col_rdata_new", t_data, 32'hAA);

    // Reset while the write address is held
    awvalid = 1'b1; awaddr = 32'h14; awid = 32'd2;
    tick();
    awvalid = 1'b0;
    chk("wd_state_readies", {awready, wready}, 2'b01);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", bvalid, 1'b0);
    chk("mid_rst_readies", {awready, wready, arready}, 3'b000);
    tick();
    reset_n = 1'b1;
    tick();
    chk("mid_rst_no_resp", bvalid, 1'b0);
    do_read(32'h04, 32'd0, t_data, t_resp, t_id, t_last);
    chk("mid_rst_r04_zero", t_data, 32'h0);
    do_read(32'h10, 32'd0, t_data, t_resp, t_id, t_last);
    chk("mid_rst_r10_zero", t_data, 32'h0);
    do_write(32'h14, 32'hCAFE0014, 32'd6, t_resp, t_id, t_lat);
    chk("post_rst_w14_resp", t_resp, 2'b00);
    chk("post_rst_w14_bid", t_id, 32'd6);
    do_read(32'h14, 32'd0, t_data, t_resp, t_id, t_last);
    chk("post_rst_r14", t_data, 32'hCAFE0014);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
AXI_LITE_SLAVE_REGS -- requirements
Module: axi_lite_slave_regs

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: width of wdata/rdata and of each register.
REQ-002 SHALL have parameter ADDR_SIZE, default 32: width of awaddr/araddr.
REQ-003 SHALL have parameter ID_SIZE, default 32: width of awid/bid/arid/rid.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports: clk input 1 (rising-edge clock), reset_n input 1 (async active-low reset).
REQ-005 Write address ports: awvalid in 1; awready out 1; awaddr in ADDR_SIZE; awid in ID_SIZE.
REQ-006 Write data ports: wvalid in 1; wready out 1; wdata in DATA_SIZE; wlast in 1 (ignored, single-beat only).
REQ-007 Write response ports: bvalid out 1; bready in 1; bresp out 2; bid out ID_SIZE.
REQ-008 Read address ports: arvalid in 1; arready out 1; araddr in ADDR_SIZE; arid in ID_SIZE.
REQ-009 Read data ports: rvalid out 1; rready in 1; rdata out DATA_SIZE; rlast out 1; rid out ID_SIZE; rresp out 2.

Function
REQ-010 SHALL implement an AXI4-lite responder with 16 registers of DATA_SIZE bits; register index = addr[5:2].
REQ-011 Decode: addr[1:0]!=0 or addr[ADDR_SIZE-1:6]!=0 -> SLVERR (2'b10), no register access; otherwise OKAY (2'b00).
REQ-012 Register 15 SHALL be read-only, returning constant REG_VERSION = 32'hA11E_0001; a write to it SHALL return SLVERR and leave all state unchanged.
REQ-013 Write FSM states: W_IDLE, W_WAIT_DATA (address held), W_WAIT_ADDR (data held), W_RESP.
REQ-014 awready=1 in W_IDLE and W_WAIT_ADDR; wready=1 in W_IDLE and W_WAIT_DATA; both 0 in W_RESP.
REQ-015 W_IDLE: aw and w handshake in the same cycle -> W_RESP; aw only -> W_WAIT_DATA (capture awaddr/awid); w only -> W_WAIT_ADDR (capture wdata).
REQ-016 W_WAIT_DATA on w handshake, or W_WAIT_ADDR on aw handshake -> W_RESP.
REQ-017 Register update SHALL occur on the same clock edge that enters W_RESP; bvalid SHALL be 1 in the following cycle (one-cycle latency from final handshake).
REQ-018 In W_RESP: bvalid=1, bid=captured awid, bresp=decode result; bvalid, bid, bresp stable until bready; on bvalid&&bready -> W_IDLE.
REQ-019 Read FSM states: R_IDLE (arready=1), R_DATA (arready=0, rvalid=1).
REQ-020 On arvalid&&arready: rdata, rresp, rid captured on that edge; enter R_DATA; rvalid in the next cycle.
REQ-021 rdata SHALL be 0 on SLVERR reads; rlast SHALL be 1 whenever rvalid=1; outputs stable until rready; on rvalid&&rready -> R_IDLE.
REQ-022 Read and write channels SHALL operate concurrently and independently.
REQ-023 Read captured on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-024 Back-to-back throughput: at most one write per 2 cycles and one read per 2 cycles.

Reset
REQ-025 While reset_n=0: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, rlast=0, bresp=0, rresp=0, bid=0, rid=0, rdata=0; FSMs in W_IDLE/R_IDLE; registers 0..14 = 0.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately, with no partial register update; after deassertion, readies assert in the first clk cycle.

Structure
REQ-027 Shared package axi_lite_pkg SHALL hold the resp typedef (OKAY=2'b00, SLVERR=2'b10), write/read state enums, NUM_REGS=16, and REG_VERSION.
REQ-028 Sub-module axi_lite_addr_decode (combinational: address -> index, valid, read-only flag) SHALL be shared by both channels.

Verification
REQ-029 aw(0x04, id 3) and w(0xDEADBEEF) in the same cycle, bready=1 -> bvalid next cycle, bresp=OKAY, bid=3; read 0x04 -> rdata=0xDEADBEEF, rlast=1.
REQ-030 w(0x12345678) three cycles before aw(0x08) -> single response after aw, OKAY; read 0x08 returns 0x12345678.
REQ-031 Write 0x3C, write 0x40, write 0x06 -> all SLVERR; read 0x3C -> 0xA11E0001; reads of 0x40/0x06 -> SLVERR, rdata=0.
REQ-032 bready held 0 for 5 cycles -> bvalid/bid/bresp stable, awready=wready=0; rready held low -> rvalid/rdata stable.
REQ-033 ar(0x10) on the same edge as the commit of a write of 0xAA to 0x10 (old value 0x55) -> rdata=0x55; next read -> 0xAA.
REQ-034 reset_n pulsed low in W_WAIT_DATA -> bvalid=0, registers=0, and a new write completes normally afterwards.
